// File: rtl/st7735_pixel_streamer.sv
// st7735_pixel_streamer: walks an X_MAX x Y_MAX raster, fetches RGB565 per pixel via a
// request/response handshake and shifts it MSB-first over a mode-0 write-only SPI link.
module st7735_pixel_streamer #(
  parameter int          X_MAX         = 160,
  parameter int          Y_MAX         = 80,
  parameter int          CLK_DIV       = 1,
  parameter int          TIMEOUT       = 1023,
  parameter logic [15:0] DEFAULT_COLOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic        next_pixel,
  input  logic [15:0] color,
  input  logic        color_done,
  output logic [15:0] timeout_cnt,
  output logic        spi_cs,
  output logic        spi_clk,
  output logic        spi_mosi,
  output logic        spi_dc
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, SHIFT, GAP, DONE} state_t;
  state_t      state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [15:0] tcnt_q, tcnt_d, wcnt_q, wcnt_d, div_q, div_d, sh_q, sh_d;
  logic [3:0]  bit_q, bit_d;
  logic        sclk_q, sclk_d;
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    tcnt_d  = tcnt_q;
    wcnt_d  = wcnt_q;
    div_d   = div_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = REQ;
        x_d     = '0;
        y_d     = '0;
        tcnt_d  = '0;
      end
      REQ: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        div_d  = '0;
        bit_d  = '0;
        sclk_d = 1'b0;
        // a response arriving on the timeout cycle is still honoured and not counted
        if (color_done) begin
          sh_d    = color;
          state_d = SHIFT;
        end else if (wcnt_q == 16'(TIMEOUT - 1)) begin
          sh_d    = DEFAULT_COLOR;
          tcnt_d  = (&tcnt_q) ? tcnt_q : tcnt_q + 16'd1;
          state_d = SHIFT;
        end else wcnt_d = wcnt_q + 16'd1;
      end
      SHIFT: begin
        div_d = (div_q == 16'(CLK_DIV - 1)) ? '0 : div_q + 16'd1;
        if (div_q == 16'(CLK_DIV - 1)) begin
          sclk_d = ~sclk_q;
          // falling edge: either move to the next bit or finish the word
          if (sclk_q && bit_q == 4'd15) state_d = GAP;
          else if (sclk_q) begin
            bit_d = bit_q + 4'd1;
            sh_d  = {sh_q[14:0], 1'b0};
          end
        end
      end
      GAP: begin
        x_d     = (x_q == 8'(X_MAX - 1)) ? '0 : x_q + 8'd1;
        y_d     = (x_q != 8'(X_MAX - 1)) ? y_q : (y_q == 7'(Y_MAX - 1)) ? '0 : y_q + 7'd1;
        state_d = (x_q == 8'(X_MAX - 1) && y_q == 7'(Y_MAX - 1)) ? DONE : REQ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      tcnt_q  <= '0;
      wcnt_q  <= '0;
      div_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tcnt_q  <= tcnt_d;
      wcnt_q  <= wcnt_d;
      div_q   <= div_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
    end
  end
  assign busy        = state_q inside {REQ, WAIT, SHIFT, GAP};
  assign frame_done  = state_q == DONE;
  assign next_pixel  = state_q inside {REQ, WAIT};
  assign x           = x_q;
  assign y           = y_q;
  assign timeout_cnt = tcnt_q;
  assign spi_cs      = ~busy;
  assign spi_clk     = sclk_q;
  assign spi_mosi    = sh_q[15];
  assign spi_dc      = 1'b1;
endmodule

// File: tb/tb_st7735_pixel_streamer.sv
// tb_st7735_pixel_streamer: directed bench with a small 4x2 raster (CLK_DIV=1) and a 2x1
// raster (CLK_DIV=3), each driven by a behavioural pixel source and SPI word capture.
module tb_st7735_pixel_streamer;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        start_a = 1'b0, busy_a, fd_a, np_a, done_a, cs_a, sclk_a, mosi_a, dc_a;
  logic [7:0]  x_a;
  logic [6:0]  y_a;
  logic [15:0] color_a, tcnt_a;
  logic        start_b = 1'b0, busy_b, fd_b, np_b, done_b, cs_b, sclk_b, mosi_b, dc_b;
  logic [7:0]  x_b;
  logic [6:0]  y_b;
  logic [15:0] color_b, tcnt_b;
  st7735_pixel_streamer #(.X_MAX(4), .Y_MAX(2), .CLK_DIV(1), .TIMEOUT(8), .DEFAULT_COLOR(16'h001F)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .frame_done(fd_a), .x(x_a), .y(y_a),
    .next_pixel(np_a), .color(color_a), .color_done(done_a), .timeout_cnt(tcnt_a), .spi_cs(cs_a),
    .spi_clk(sclk_a), .spi_mosi(mosi_a), .spi_dc(dc_a));
  st7735_pixel_streamer #(.X_MAX(2), .Y_MAX(1), .CLK_DIV(3), .TIMEOUT(8), .DEFAULT_COLOR(16'h001F)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .frame_done(fd_b), .x(x_b), .y(y_b),
    .next_pixel(np_b), .color(color_b), .color_done(done_b), .timeout_cnt(tcnt_b), .spi_cs(cs_b),
    .spi_clk(sclk_b), .spi_mosi(mosi_b), .spi_dc(dc_b));
  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // source A: mode 0 answers 2 cycles after the rise, 1 never answers, 2 answers on the timeout cycle
  int mode_a = 0, k_a = 0, nreq_a = 0, run_a = 0, hrun_a = 0;
  logic [15:0] cval_a = 16'hF800;
  logic spur_a = 1'b0, npp_a = 1'b0;
  logic [7:0] rx[0:63];
  logic [6:0] ry[0:63];
  initial begin
    done_a = 1'b0; color_a = '0;
    forever begin
      @(negedge clk);
      done_a = 1'b0;
      if (np_a) begin
        if (!npp_a) begin
          k_a = 0; run_a = 1;
          if (nreq_a < 64) begin rx[nreq_a] = x_a; ry[nreq_a] = y_a; end
          nreq_a++;
        end else begin k_a++; run_a++; end
        if ((mode_a == 0 && k_a == 2) || (mode_a == 2 && k_a == 8)) begin done_a = 1'b1; color_a = cval_a; end
      end else if (npp_a) hrun_a = run_a;
      if (spur_a) begin done_a = 1'b1; color_a = 16'h5555; end
      npp_a = np_a;
    end
  end
  int nb_a = 0, nw_a = 0, nfd_a = 0;
  logic [15:0] sw_a = '0;
  logic [15:0] words_a[0:127];
  initial forever begin
    @(posedge sclk_a or negedge rst_n);
    if (!rst_n) nb_a = 0;
    else begin
      sw_a = {sw_a[14:0], mosi_a};
      nb_a++;
      if (nb_a % 16 == 0) begin
        if (nw_a < 128) words_a[nw_a] = sw_a;
        nw_a++;
      end
    end
  end
  initial forever begin @(negedge clk); if (fd_a) nfd_a++; end
  // source B always answers 2 cycles after the rise
  int k_b = 0, nreq_b = 0, lrun_b = 0, gap_b = 0;
  logic npp_b = 1'b0;
  logic [7:0] rxb[0:3];
  logic [6:0] ryb[0:3];
  initial begin
    done_b = 1'b0; color_b = '0;
    forever begin
      @(negedge clk);
      done_b = 1'b0;
      if (np_b) begin
        if (!npp_b) begin
          k_b = 0;
          if (nreq_b > 0) gap_b = lrun_b;
          if (nreq_b < 4) begin rxb[nreq_b] = x_b; ryb[nreq_b] = y_b; end
          nreq_b++;
        end else k_b++;
        if (k_b == 2) begin done_b = 1'b1; color_b = 16'h5A3C; end
      end else lrun_b = npp_b ? 1 : lrun_b + 1;
      npp_b = np_b;
    end
  end
  int nb_b = 0, nw_b = 0, nfd_b = 0, r_b = 0, hmin = 999, hmax = 0, lmin = 999, lmax = 0;
  logic pl_b = 1'b0;
  logic [15:0] sw_b = '0;
  logic [15:0] words_b[0:3];
  initial forever begin
    @(posedge sclk_b);
    sw_b = {sw_b[14:0], mosi_b};
    nb_b++;
    if (nb_b % 16 == 0) begin
      if (nw_b < 4) words_b[nw_b] = sw_b;
      nw_b++;
    end
  end
  initial forever begin
    @(negedge clk);
    if (fd_b) nfd_b++;
    if (sclk_b == pl_b) r_b++;
    else begin
      if (pl_b) begin hmin = (r_b < hmin) ? r_b : hmin; hmax = (r_b > hmax) ? r_b : hmax; end
      else if (nb_b % 16 != 1) begin lmin = (r_b < lmin) ? r_b : lmin; lmax = (r_b > lmax) ? r_b : lmax; end
      r_b = 1;
    end
    pl_b = sclk_b;
  end
  task automatic pulse_a();
    @(posedge clk); #2 start_a = 1'b1;
    @(posedge clk); #2 start_a = 1'b0;
  endtask
  task automatic wait_frame_a(input string t, input int f0);
    for (int i = 0; i < 2000 && nfd_a == f0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({t, "_frame_done"}, nfd_a - f0, 1);
  endtask
  task automatic wait_words_a(input string t, input int n);
    for (int i = 0; i < 2000 && nw_a < n; i++) @(negedge clk);
    chk({t, "_words_reached"}, 32'(nw_a >= n), 1);
  endtask
  task automatic check_frame_a(input string t, input int r0, input int w0, input logic [15:0] w,
                               input int tc, input int hr);
    chk({t, "_nreq"}, nreq_a - r0, 8);
    chk({t, "_nwords"}, nw_a - w0, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_xy%0d", t, i), {17'd0, rx[r0 + i], ry[r0 + i]}, {17'd0, 8'(i % 4), 7'(i / 4)});
      chk($sformatf("%s_word%0d", t, i), {16'd0, words_a[w0 + i]}, {16'd0, w});
    end
    chk({t, "_timeout_cnt"}, {16'd0, tcnt_a}, tc);
    chk({t, "_req_len"}, hrun_a, hr);
    chk({t, "_idle"}, {busy_a, cs_a, np_a, x_a, y_a}, {3'b010, 15'd0});
  endtask
  int r0, w0, f0;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ctl_a", {busy_a, fd_a, np_a, cs_a, sclk_a, mosi_a, dc_a}, 7'b0001001);
    chk("rst_xy_a", {x_a, y_a, tcnt_a}, 0);
    chk("rst_ctl_b", {busy_b, fd_b, np_b, cs_b, sclk_b, mosi_b, dc_b}, 7'b0001001);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // 1: prompt source, F800
    r0 = nreq_a; w0 = nw_a; f0 = nfd_a;
    pulse_a();
    chk("t1_busy_cs_np", {busy_a, cs_a, np_a}, 3'b101);
    wait_frame_a("t1", f0);
    check_frame_a("t1", r0, w0, 16'hF800, 0, 3);
    // 2: silent source, default colour on every pixel
    mode_a = 1;
    r0 = nreq_a; w0 = nw_a; f0 = nfd_a;
    pulse_a();
    wait_frame_a("t2", f0);
    check_frame_a("t2", r0, w0, 16'h001F, 8, 9);
    // 3: response on the timeout cycle
    mode_a = 2; cval_a = 16'hABCD;
    r0 = nreq_a; w0 = nw_a; f0 = nfd_a;
    pulse_a();
    wait_frame_a("t3", f0);
    check_frame_a("t3", r0, w0, 16'hABCD, 0, 9);
    // 4: start and a stray response while shifting
    mode_a = 0; cval_a = 16'h1234;
    r0 = nreq_a; w0 = nw_a; f0 = nfd_a;
    pulse_a();
    wait_words_a("t4", w0 + 2);
    repeat (10) @(negedge clk);
    chk("t4_in_shift", {busy_a, np_a}, 2'b10);
    @(posedge clk); #2 spur_a = 1'b1; start_a = 1'b1;
    @(posedge clk); #2 spur_a = 1'b0; start_a = 1'b0;
    wait_frame_a("t4", f0);
    check_frame_a("t4", r0, w0, 16'h1234, 0, 3);
    // 5: reset mid-shift, then a clean frame
    cval_a = 16'hF800;
    w0 = nw_a;
    pulse_a();
    wait_words_a("t5", w0 + 3);
    repeat (15) @(negedge clk);
    chk("t5_in_shift", {busy_a, np_a}, 2'b10);
    #2 rst_n = 1'b0;
    #1 chk("t5_async_rst", {cs_a, sclk_a, busy_a, np_a}, 4'b1000);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    r0 = nreq_a; w0 = nw_a; f0 = nfd_a;
    pulse_a();
    wait_frame_a("t5", f0);
    check_frame_a("t5", r0, w0, 16'hF800, 0, 3);
    // 6: CLK_DIV=3 on the 2x1 instance
    @(posedge clk); #2 start_b = 1'b1;
    @(posedge clk); #2 start_b = 1'b0;
    for (int i = 0; i < 2000 && nfd_b == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t6_frame_done", nfd_b, 1);
    chk("t6_nreq", nreq_b, 2);
    chk("t6_xy", {rxb[0], ryb[0], rxb[1], ryb[1]}, {8'd0, 7'd0, 8'd1, 7'd0});
    chk("t6_words", {words_b[0], words_b[1]}, {16'h5A3C, 16'h5A3C});
    chk("t6_high_run", {hmin, hmax}, {32'd3, 32'd3});
    chk("t6_low_run", {lmin, lmax}, {32'd3, 32'd3});
    chk("t6_req_gap", gap_b, 97);
    chk("t6_idle", {busy_b, cs_b, sclk_b, tcnt_b}, {3'b010, 16'd0});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
